// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The core drives the master side; the unit is the slave.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fix at the end.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | iterating, cnt_q counts 0..XLEN-1
//   FIN    | result registered, done high for one cycle
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic          clk_i,
  input  logic          resetb_i,
  muldiv_unit_if.slave  md_io
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_MULHSU = 3'b010;

  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam bit              EO       = (EARLY_OUT != 0);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rs1_q, neg_rs1_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode on the request side
  logic            in_s1, in_s2, in_neg1, in_neg2, in_dz, in_ovf, in_early;
  logic [XLEN-1:0] in_mag1, in_mag2;

  assign in_s1    = !(md_io.op[0] && (md_io.op[1] || md_io.op[2]));
  assign in_s2    = in_s1 && (md_io.op != OP_MULHSU);
  assign in_neg1  = in_s1 && md_io.rs1[XLEN-1];
  assign in_neg2  = in_s2 && md_io.rs2[XLEN-1];
  assign in_mag1  = in_neg1 ? (XLEN'(0) - md_io.rs1) : md_io.rs1;
  assign in_mag2  = in_neg2 ? (XLEN'(0) - md_io.rs2) : md_io.rs2;
  assign in_dz    = md_io.op[2] && (md_io.rs2 == '0);
  assign in_ovf   = md_io.op[2] && !md_io.op[0] &&
                    (md_io.rs1 == MOST_NEG) && (md_io.rs2 == '1);
  assign in_early = EO && (in_dz || in_ovf);

  // One iteration step. Multiply: prod = {acc, multiplier}, add then shift right.
  // Divide: prod = {remainder, dividend/quotient}, shift left then trial subtract.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_up;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step;

  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  assign div_up   = prod_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_up - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_up[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

  assign step = op_q[2] ? div_next : mul_next;

  function automatic logic [XLEN-1:0] finish_result(
    input logic [2:0]        op,
    input logic [2*XLEN-1:0] prod,
    input logic              neg_res,
    input logic              neg_rs1,
    input logic              dz,
    input logic              ovf,
    input logic [XLEN-1:0]   rs1
  );
    logic [2*XLEN-1:0] p_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   r;
    p_fix = neg_res ? ((2*XLEN)'(0) - prod) : prod;
    quo   = neg_res ? (XLEN'(0) - prod[XLEN-1:0]) : prod[XLEN-1:0];
    rem   = neg_rs1 ? (XLEN'(0) - prod[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN];
    if (!op[2]) begin
      r = (op[1:0] == 2'b00) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
    end else if (dz) begin
      r = op[1] ? rs1 : '1;
    end else if (ovf) begin
      r = op[1] ? '0 : rs1;
    end else begin
      r = op[1] ? rem : quo;
    end
    return r;
  endfunction

  logic accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rs1_d     = rs1_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rs1_d = neg_rs1_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    accept    = 1'b0;

    case (state_q)
      S_RUN: begin
        if (md_io.kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          prod_d = step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_FIN;
            cnt_d    = '0;
            result_d = finish_result(op_q, step, neg_res_q, neg_rs1_q,
                                     dz_q, ovf_q, rs1_q);
          end
        end
      end
      default: begin
        // IDLE and FIN both return to IDLE unless a new request is taken
        state_d = S_IDLE;
        accept  = md_io.start && !md_io.kill;
      end
    endcase

    if (accept) begin
      op_d      = md_io.op;
      a_d       = in_mag1;
      b_d       = in_mag2;
      rs1_d     = md_io.rs1;
      prod_d    = {{XLEN{1'b0}}, (md_io.op[2] ? in_mag1 : in_mag2)};
      neg_res_d = in_neg1 ^ in_neg2;
      neg_rs1_d = in_neg1;
      dz_d      = in_dz;
      ovf_d     = in_ovf;
      cnt_d     = '0;
      if (in_early) begin
        state_d  = S_FIN;
        result_d = finish_result(md_io.op, '0, 1'b0, 1'b0,
                                 in_dz, in_ovf, md_io.rs1);
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rs1_q     <= '0;
      prod_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rs1_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs1_q     <= rs1_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rs1_q <= neg_rs1_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign md_io.busy   = (state_q == S_RUN);
  assign md_io.done   = (state_q == S_FIN);
  assign md_io.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit with a result scoreboard:
// XLEN=32 with and without early-out, plus an XLEN=16 instance.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rstb;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q [$];

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) ifa ();
  muldiv_unit_if #(.XLEN(32)) ifb ();
  muldiv_unit_if #(.XLEN(16)) ifc ();

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) dut_a (.clk_i(clk), .resetb_i(rstb), .md_io(ifa));
  muldiv_unit #(.XLEN(32), .EARLY_OUT(0)) dut_b (.clk_i(clk), .resetb_i(rstb), .md_io(ifb));
  muldiv_unit #(.XLEN(16), .EARLY_OUT(0)) dut_c (.clk_i(clk), .resetb_i(rstb), .md_io(ifc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0: begin ifa.start = s; ifa.op = op; ifa.rs1 = a; ifa.rs2 = b; end
      1: begin ifb.start = s; ifb.op = op; ifb.rs1 = a; ifb.rs2 = b; end
      default: begin ifc.start = s; ifc.op = op; ifc.rs1 = a[15:0]; ifc.rs2 = b[15:0]; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic s);
    case (sel)
      0: ifa.start = s;
      1: ifb.start = s;
      default: ifc.start = s;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return ifa.done;
      1: return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return ifa.busy;
      1: return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      0: return ifa.result;
      1: return ifb.result;
      default: return {16'h0, ifc.result};
    endcase
  endfunction

  // Reference behaviour of the M-extension ops at XLEN=32
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic        ovf;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      MUL:    begin up = {32'h0, a} * {32'h0, b}; r = up[31:0]; end
      MULH:   begin sp = sa * sb; r = sp[63:32]; end
      MULHSU: begin sp = sa * $signed({32'h0, b}); r = sp[63:32]; end
      MULHU:  begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
      DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge (k=1)
  task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit push);
    drive(sel, 1'b1, op, a, b);
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  // Waits for done from k=1, checks latency, busy cycles and the scoreboard head
  task automatic collect(input int sel, input int lat, input int nbusy,
                         input string tag, input int glitch_at);
    int k  = 1;
    int nb = 0;
    logic [31:0] expv;
    while (!get_done(sel) && k < 200) begin
      if (get_busy(sel)) nb++;
      if (glitch_at > 0) set_start(sel, k == glitch_at);
      @(negedge clk);
      k++;
    end
    check({tag, "/lat"}, 32'(k), 32'(lat));
    check({tag, "/busy"}, 32'(nb), 32'(nbusy));
    check({tag, "/sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check({tag, "/res"}, get_res(sel), expv);
    end
  endtask

  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat,
                        input string tag);
    issue(sel, op, a, b, expv, 1'b1);
    collect(sel, lat, lat - 1, tag, 0);
    @(negedge clk);
    check({tag, "/pulse"}, {31'h0, get_done(sel)}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          sp;

    rstb = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, MUL, 32'h0, 32'h0);
    ifa.kill = 1'b0; ifb.kill = 1'b0; ifc.kill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d/busy", s), {31'h0, get_busy(s)}, 32'h0);
      check($sformatf("rst%0d/done", s), {31'h0, get_done(s)}, 32'h0);
      check($sformatf("rst%0d/res", s), get_res(s), 32'h0);
    end
    rstb = 1'b1;
    @(negedge clk);

    // Multiply and divide, XLEN=32, early-out enabled
    run_op(0, MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_op(0, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_op(0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(0, DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
    run_op(0, REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
    run_op(0, DIVU,   32'd100,       32'd7,         32'd14,        33, "divu");
    run_op(0, REMU,   32'd100,       32'd7,         32'd2,         33, "remu");

    // Special cases with early-out
    run_op(0, DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "eo_divu0");
    run_op(0, REMU, 32'd5,         32'd0,         32'd5,         1, "eo_remu0");
    run_op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "eo_divovf");
    run_op(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "eo_removf");
    run_op(0, DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, "eo_divneg0");
    run_op(0, REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, "eo_remneg0");

    // Same special cases iterated, early-out disabled
    run_op(1, DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, "it_divu0");
    run_op(1, REMU, 32'd5,         32'd0,         32'd5,         33, "it_remu0");
    run_op(1, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "it_divovf");
    run_op(1, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33, "it_removf");
    run_op(1, REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 33, "it_remneg0");

    // XLEN=16 instance
    run_op(2, MULH, 32'h8000, 32'h7FFF, 32'hC000, 17, "x16_mulh");
    run_op(2, DIV,  32'h8000, 32'hFFFF, 32'h8000, 17, "x16_divovf");

    // Random operations against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      sp  = rop[2] && ((rb == 0) || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      run_op(0, rop, ra, rb, ref_op(rop, ra, rb), sp ? 1 : 33, $sformatf("rand%0d", i));
    end

    // Kill in RUN cycle 10
    run_op(0, MUL, 32'd3, 32'd5, 32'd15, 33, "pre_kill");
    issue(0, DIVU, 32'd100, 32'd7, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    ifa.kill = 1'b1;
    @(negedge clk);
    ifa.kill = 1'b0;
    check("kill/busy", {31'h0, ifa.busy}, 32'h0);
    done_seen = 0;
    repeat (40) begin
      if (ifa.done) done_seen++;
      @(negedge clk);
    end
    check("kill/done", 32'(done_seen), 32'h0);
    check("kill/res", ifa.result, 32'd15);

    // Kill in IDLE blocks a simultaneous start
    ifa.kill = 1'b1;
    drive(0, 1'b1, MUL, 32'd2, 32'd2);
    @(negedge clk);
    ifa.kill = 1'b0;
    set_start(0, 1'b0);
    check("kill_idle/busy", {31'h0, ifa.busy}, 32'h0);
    done_seen = 0;
    repeat (40) begin
      if (ifa.done) done_seen++;
      @(negedge clk);
    end
    check("kill_idle/done", 32'(done_seen), 32'h0);
    check("kill_idle/res", ifa.result, 32'd15);

    // Back-to-back, plus a start pulse while busy that must be ignored
    issue(0, MUL, 32'd6, 32'd7, 32'd42, 1'b1);
    collect(0, 33, 32, "b2b1", 0);
    issue(0, DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    check("b2b/busy_next", {31'h0, ifa.busy}, 32'h1);
    collect(0, 33, 32, "b2b2", 5);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.done) done_seen++;
    end
    check("b2b/extra_done", 32'(done_seen), 32'h0);

    // Reset in RUN cycle 5
    issue(0, MUL, 32'd9, 32'd9, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", {31'h0, ifa.busy}, 32'h0);
    check("rst_mid/done", {31'h0, ifa.done}, 32'h0);
    check("rst_mid/res", ifa.result, 32'h0);
    rstb = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.done) done_seen++;
    end
    check("rst_mid/no_done", 32'(done_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
